// File: rtl/tx_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tx_rr_arb
// Description : Round-robin arbiter merging NUM_CH valid/ready TX channels
//               into one registered output slot (1 beat/cycle throughput).
//               Optional packet lock: define TX_RR_ARB_PKT_LOCK_EN to keep the
//               grant on one channel from its first beat until in_last.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_rr_arb #(
    parameter int  NUM_CH = 4,
    parameter int  DATA_W = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic                     rdy,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_ch
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_last_q;
    logic [CH_W-1:0]     out_ch_q;
    logic [CH_W-1:0]     ptr_q;
    logic                lock_q;
    logic [CH_W-1:0]     lock_ch_q;

    logic                gnt_found;
    logic [CH_W-1:0]     gnt_idx;
    logic [CH_W-1:0]     cand;
    logic                load_ok;
    logic                accept;

    // Grant search: locked channel only, otherwise first valid after ptr with wrap
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (lock_q) begin
            gnt_found = in_valid[lock_ch_q];
            gnt_idx   = lock_ch_q;
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                cand = CH_W'((int'(ptr_q) + k) % NUM_CH);
                if (!gnt_found && in_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    // Slot may load when empty or draining this cycle; reset forces no acceptance
    assign load_ok  = !out_valid_q || out_ready;
    assign accept   = rst && en && load_ok && gnt_found;
    assign in_ready = accept ? (NUM_CH'(1) << gnt_idx) : '0;

    assign rdy       = rst && (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

    // Output slot, round-robin pointer, packet lock and state tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= CH_W'(NUM_CH - 1);
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
        end else if (accept) begin
            state_q     <= ST_BUSY;
            out_valid_q <= 1'b1;
            out_data_q  <= in_data[gnt_idx*DATA_W +: DATA_W];
            out_last_q  <= in_last[gnt_idx];
            out_ch_q    <= gnt_idx;
            ptr_q       <= gnt_idx;
`ifdef TX_RR_ARB_PKT_LOCK_EN
            lock_q      <= !in_last[gnt_idx];
            lock_ch_q   <= gnt_idx;
`endif
        end else if (out_valid_q && out_ready) begin
            // Drain without refill: slot empties, packet may still be open
            out_valid_q <= 1'b0;
            state_q     <= lock_q ? ST_LOCKED : ST_IDLE;
        end
    end

endmodule
`default_nettype wire
